// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : proc_pkg
// Description : Shared opcodes, FSM state encoding and instruction field
//               positions for the proc_multi core.
// Revision    : 1.0 - initial release
// ============================================================================
package proc_pkg;

    localparam logic [3:0] OP_HALT   = 4'h0;
    localparam logic [3:0] OP_OUTI   = 4'h1;
    localparam logic [3:0] OP_OUTLOC = 4'h2;
    localparam logic [3:0] OP_LI     = 4'h3;
    localparam logic [3:0] OP_OUTR   = 4'h4;
    localparam logic [3:0] OP_LOAD   = 4'h5;
    localparam logic [3:0] OP_STORE  = 4'h6;
    localparam logic [3:0] OP_ADDI   = 4'h7;
    localparam logic [3:0] OP_BNZ    = 4'h8;

    localparam int INSTR_RD_MSB  = 15;
    localparam int INSTR_RD_LSB  = 12;
    localparam int INSTR_OP_MSB  = 11;
    localparam int INSTR_OP_LSB  = 8;
    localparam int INSTR_IMM_MSB = 7;
    localparam int INSTR_IMM_LSB = 0;

    typedef enum logic [2:0] {
        RESET      = 3'd0,
        WAIT_INSTR = 3'd1,
        EXEC       = 3'd2,
        MEM_WAIT   = 3'd3,
        HALTED     = 3'd4
    } e_state;

endpackage
`default_nettype wire

// File: rtl/proc_regfile.sv
`default_nettype none
// ============================================================================
// Module      : proc_regfile
// Description : NUM_REGS x DATA_W register file, one synchronous write port,
//               combinational operand and debug read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module proc_regfile #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [3:0]        i_wsel,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [3:0]        i_rd_sel,
    output logic [DATA_W-1:0] o_rd_data,
    input  logic [3:0]        i_dbg_sel,
    output logic [DATA_W-1:0] o_dbg_data
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (i_we) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (i_wsel == 4'(i)) r_regs[i] <= i_wdata;
            end
        end
    end

    // Indices with no backing register read as zero.
    always_comb begin
        o_rd_data  = '0;
        o_dbg_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i_rd_sel == 4'(i))  o_rd_data  = r_regs[i];
            if (i_dbg_sel == 4'(i)) o_dbg_data = r_regs[i];
        end
    end

endmodule
`default_nettype wire

// File: rtl/proc_multi.sv
`default_nettype none
// ============================================================================
// Module      : proc_multi
// Description : Parametrised multi-cycle processor core with a req/ack
//               memory port, load/store, add-immediate, branch and halt.
// Revision    : 1.0 - initial release
// ============================================================================
module proc_multi
    import proc_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] out,
    output logic              outen,
    output logic [ADDR_W-1:0] pc,
    output logic [2:0]        state,
    output logic              halted,
    output logic              illegal,
    input  logic [3:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    e_state            r_state;
    logic [15:0]       r_ir;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [15:0]       r_mem_wdata;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_out;
    logic              r_outen;
    logic              r_halted;
    logic              r_illegal;

    logic [3:0]        w_rd;
    logic [3:0]        w_op;
    logic [7:0]        w_imm;
    logic [DATA_W-1:0] w_imm_d;
    logic [ADDR_W-1:0] w_imm_a;
    logic              w_legal;
    logic              w_ack;
    logic [DATA_W-1:0] w_rd_val;
    logic [DATA_W-1:0] w_load_data;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_exec_next_pc;
    logic              w_rf_we;
    logic [DATA_W-1:0] w_rf_wdata;

    assign w_rd        = r_ir[INSTR_RD_MSB:INSTR_RD_LSB];
    assign w_op        = r_ir[INSTR_OP_MSB:INSTR_OP_LSB];
    assign w_imm       = r_ir[INSTR_IMM_MSB:INSTR_IMM_LSB];
    assign w_imm_d     = DATA_W'(w_imm);
    assign w_imm_a     = ADDR_W'(w_imm);
    assign w_legal     = (w_op <= OP_BNZ) && (int'(w_rd) < NUM_REGS);
    assign w_ack       = mem_ack & r_mem_req;
    assign w_load_data = DATA_W'(mem_rdata);
    assign w_pc_inc    = r_pc + ADDR_W'(1);

    assign w_exec_next_pc = (w_op == OP_BNZ && w_rd_val != '0) ? w_imm_a : w_pc_inc;

    // LI/ADDI write while executing; LOAD writes when its data beat completes.
    assign w_rf_we = (r_state == EXEC && w_legal && (w_op == OP_LI || w_op == OP_ADDI))
                  || (r_state == MEM_WAIT && w_ack && w_op == OP_LOAD);

    assign w_rf_wdata = (r_state == MEM_WAIT) ? w_load_data
                      : (w_op == OP_ADDI)     ? w_rd_val + w_imm_d
                      :                         w_imm_d;

    proc_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .i_we       (w_rf_we),
        .i_wsel     (w_rd),
        .i_wdata    (w_rf_wdata),
        .i_rd_sel   (w_rd),
        .o_rd_data  (w_rd_val),
        .i_dbg_sel  (dbg_sel),
        .o_dbg_data (dbg_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RESET;
            r_ir        <= '0;
            r_pc        <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_out       <= '0;
            r_outen     <= 1'b0;
            r_halted    <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_outen <= 1'b0;
            case (r_state)
                RESET: begin
                    r_mem_req  <= 1'b1;
                    r_mem_we   <= 1'b0;
                    r_mem_addr <= r_pc;
                    r_state    <= WAIT_INSTR;
                end
                WAIT_INSTR: begin
                    if (w_ack) begin
                        r_ir      <= mem_rdata;
                        r_mem_req <= 1'b0;
                        r_state   <= EXEC;
                    end
                end
                EXEC: begin
                    if (!w_legal) begin
                        r_illegal <= 1'b1;
                        r_halted  <= 1'b1;
                        r_state   <= HALTED;
                    end else begin
                        case (w_op)
                            OP_HALT: begin
                                r_halted <= 1'b1;
                                r_state  <= HALTED;
                            end
                            OP_OUTLOC, OP_LOAD, OP_STORE: begin
                                r_mem_req  <= 1'b1;
                                r_mem_we   <= (w_op == OP_STORE);
                                r_mem_addr <= w_imm_a;
                                if (w_op == OP_STORE) r_mem_wdata <= 16'(w_rd_val);
                                r_state    <= MEM_WAIT;
                            end
                            default: begin
                                if (w_op == OP_OUTI) begin
                                    r_out   <= w_imm_d;
                                    r_outen <= 1'b1;
                                end else if (w_op == OP_OUTR) begin
                                    r_out   <= w_rd_val;
                                    r_outen <= 1'b1;
                                end
                                r_pc       <= w_exec_next_pc;
                                r_mem_req  <= 1'b1;
                                r_mem_we   <= 1'b0;
                                r_mem_addr <= w_exec_next_pc;
                                r_state    <= WAIT_INSTR;
                            end
                        endcase
                    end
                end
                MEM_WAIT: begin
                    // req stays high: the data beat ends and the next fetch starts on one edge.
                    if (w_ack) begin
                        if (w_op == OP_OUTLOC) begin
                            r_out   <= w_load_data;
                            r_outen <= 1'b1;
                        end
                        r_pc       <= w_pc_inc;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= w_pc_inc;
                        r_state    <= WAIT_INSTR;
                    end
                end
                HALTED: begin
                    r_state <= HALTED;
                end
                default: begin
                    r_state <= HALTED;
                end
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign out       = r_out;
    assign outen     = r_outen;
    assign pc        = r_pc;
    assign state     = r_state;
    assign halted    = r_halted;
    assign illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_proc_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_proc_multi
// Description : Directed self-checking bench for proc_multi (DATA_W=8,
//               NUM_REGS=8) with a variable-latency req/ack memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_proc_multi;

    localparam int DW = 8;
    localparam int NR = 8;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic [15:0]   mem_rdata;
    logic          mem_ack;
    logic [DW-1:0] out;
    logic          outen;
    logic [AW-1:0] pc;
    logic [2:0]    state;
    logic          halted;
    logic          illegal;
    logic [3:0]    dbg_sel = 4'd0;
    logic [DW-1:0] dbg_data;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem [256];
    int          ack_delay  = 0;
    int          wait_cnt   = 0;
    int          cyc        = 0;
    int          outen_cnt  = 0;
    int          wr_cnt     = 0;
    logic [15:0] last_waddr = 16'h0;
    logic [15:0] last_wdata = 16'h0;

    always #5 clk = ~clk;

    proc_multi #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .out       (out),
        .outen     (outen),
        .pc        (pc),
        .state     (state),
        .halted    (halted),
        .illegal   (illegal),
        .dbg_sel   (dbg_sel),
        .dbg_data  (dbg_data)
    );

    // Memory answers each request after ack_delay extra cycles.
    assign mem_ack   = mem_req && (wait_cnt == ack_delay);
    assign mem_rdata = mem[mem_addr[7:0]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (outen) outen_cnt <= outen_cnt + 1;
        if (mem_req && mem_ack) begin
            wait_cnt <= 0;
            if (mem_we) begin
                mem[mem_addr[7:0]] <= mem_wdata;
                wr_cnt     <= wr_cnt + 1;
                last_waddr <= mem_addr;
                last_wdata <= mem_wdata;
            end
        end else if (mem_req) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mem;
        for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
    endtask

    task automatic run_to_halt(input int budget, input int c0, output int cycles);
        int n;
        n = 0;
        while (!halted && n < budget) begin
            step(1);
            n++;
        end
        cycles = cyc - c0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        clear_mem;
        step(2);
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %0b want 0", mem_req); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_we: got %0b want 0", mem_we); end
        total++; if (mem_addr !== 16'h0) begin bad++; $display("FAIL rst_addr: got %0h want 0", mem_addr); end
        total++; if (mem_wdata !== 16'h0) begin bad++; $display("FAIL rst_wdata: got %0h want 0", mem_wdata); end
        total++; if (out !== 8'h0 || outen !== 1'b0) begin bad++; $display("FAIL rst_out: got out=%0h outen=%0b want 0/0", out, outen); end
        total++; if (pc !== 16'h0) begin bad++; $display("FAIL rst_pc: got %0h want 0", pc); end
        total++; if (state !== 3'd0) begin bad++; $display("FAIL rst_state: got %0d want 0", state); end
        total++; if (halted !== 1'b0 || illegal !== 1'b0) begin bad++; $display("FAIL rst_flags: got halted=%0b illegal=%0b want 0/0", halted, illegal); end
    endtask

    task automatic test_outi;
        int c0, o0, cycles;
        rst = 1'b1; ack_delay = 0; clear_mem;
        mem[0] <= 16'h0105;
        mem[1] <= 16'h0000;
        step(2);
        o0 = outen_cnt; rst = 1'b0; c0 = cyc;
        step(2);
        total++; if (outen !== 1'b0) begin bad++; $display("FAIL outi_early: outen got %0b want 0", outen); end
        step(1);
        total++; if (outen !== 1'b1 || out !== 8'h05) begin bad++; $display("FAIL outi_cycle3: got outen=%0b out=%0h want 1/05", outen, out); end
        run_to_halt(50, c0, cycles);
        total++; if (cycles !== 5) begin bad++; $display("FAIL outi_cycles: got %0d want 5", cycles); end
        total++; if (outen_cnt - o0 !== 1) begin bad++; $display("FAIL outi_pulses: got %0d want 1", outen_cnt - o0); end
        total++; if (halted !== 1'b1 || illegal !== 1'b0) begin bad++; $display("FAIL outi_flags: got halted=%0b illegal=%0b want 1/0", halted, illegal); end
        total++; if (pc !== 16'd1) begin bad++; $display("FAIL outi_pc: got %0h want 1", pc); end
        total++; if (state !== 3'd4) begin bad++; $display("FAIL outi_state: got %0d want 4", state); end
    endtask

    task automatic test_addi_wrap;
        int c0, cycles;
        rst = 1'b1; ack_delay = 0; clear_mem;
        mem[0] <= 16'h1303;
        mem[1] <= 16'h17FF;
        mem[2] <= 16'h0000;
        dbg_sel = 4'd1;
        step(2);
        rst = 1'b0; c0 = cyc;
        step(2);
        #1;
        total++; if (dbg_data !== 8'h00) begin bad++; $display("FAIL addi_li_before: got %0h want 00", dbg_data); end
        step(1);
        #1;
        total++; if (dbg_data !== 8'h03) begin bad++; $display("FAIL addi_li_after: got %0h want 03", dbg_data); end
        step(1);
        #1;
        total++; if (dbg_data !== 8'h03) begin bad++; $display("FAIL addi_old_value: got %0h want 03", dbg_data); end
        step(1);
        #1;
        total++; if (dbg_data !== 8'h02) begin bad++; $display("FAIL addi_wrap: got %0h want 02", dbg_data); end
        run_to_halt(50, c0, cycles);
        total++; if (cycles !== 7) begin bad++; $display("FAIL addi_cycles: got %0d want 7", cycles); end
        dbg_sel = 4'd9;
        #1;
        total++; if (dbg_data !== 8'h00) begin bad++; $display("FAIL dbg_out_of_range: got %0h want 00", dbg_data); end
        dbg_sel = 4'd0;
        #1;
        total++; if (dbg_data !== 8'h00) begin bad++; $display("FAIL dbg_r0: got %0h want 00", dbg_data); end
    endtask

    task automatic test_loop;
        int c0, o0, cycles;
        rst = 1'b1; ack_delay = 0; clear_mem;
        mem[0] <= 16'h2303;
        mem[1] <= 16'h27FF;
        mem[2] <= 16'h2801;
        mem[3] <= 16'h2400;
        mem[4] <= 16'h0000;
        step(2);
        o0 = outen_cnt; rst = 1'b0; c0 = cyc;
        run_to_halt(100, c0, cycles);
        total++; if (cycles !== 19) begin bad++; $display("FAIL loop_cycles: got %0d want 19", cycles); end
        total++; if (out !== 8'h00) begin bad++; $display("FAIL loop_out: got %0h want 00", out); end
        total++; if (outen_cnt - o0 !== 1) begin bad++; $display("FAIL loop_pulses: got %0d want 1", outen_cnt - o0); end
        total++; if (pc !== 16'd4) begin bad++; $display("FAIL loop_pc: got %0h want 4", pc); end
    endtask

    task automatic test_store_load(input int d);
        int c0, o0, w0, cycles;
        rst = 1'b1; ack_delay = d; clear_mem;
        mem[0] <= 16'h13A5;
        mem[1] <= 16'h1620;
        mem[2] <= 16'h3520;
        mem[3] <= 16'h3400;
        mem[4] <= 16'h0000;
        step(2);
        o0 = outen_cnt; w0 = wr_cnt; rst = 1'b0; c0 = cyc;
        run_to_halt(200, c0, cycles);
        total++; if (cycles !== 13 + 7 * d) begin bad++; $display("FAIL sl_cycles_d%0d: got %0d want %0d", d, cycles, 13 + 7 * d); end
        total++; if (wr_cnt - w0 !== 1) begin bad++; $display("FAIL sl_writes_d%0d: got %0d want 1", d, wr_cnt - w0); end
        total++; if (last_waddr !== 16'h0020 || last_wdata !== 16'h00A5) begin bad++; $display("FAIL sl_beat_d%0d: got addr=%0h data=%0h want 20/00a5", d, last_waddr, last_wdata); end
        total++; if (out !== 8'hA5 || outen_cnt - o0 !== 1) begin bad++; $display("FAIL sl_out_d%0d: got out=%0h pulses=%0d want a5/1", d, out, outen_cnt - o0); end
        dbg_sel = 4'd3;
        #1;
        total++; if (dbg_data !== 8'hA5) begin bad++; $display("FAIL sl_r3_d%0d: got %0h want a5", d, dbg_data); end
        total++; if (pc !== 16'd4) begin bad++; $display("FAIL sl_pc_d%0d: got %0h want 4", d, pc); end
    endtask

    task automatic test_illegal_op;
        int c0, cycles;
        rst = 1'b1; ack_delay = 0; clear_mem;
        mem[0] <= 16'h1305;
        mem[1] <= 16'h1A00;
        step(2);
        rst = 1'b0; c0 = cyc;
        run_to_halt(50, c0, cycles);
        total++; if (cycles !== 5) begin bad++; $display("FAIL illop_cycles: got %0d want 5", cycles); end
        total++; if (illegal !== 1'b1 || halted !== 1'b1) begin bad++; $display("FAIL illop_flags: got illegal=%0b halted=%0b want 1/1", illegal, halted); end
        total++; if (pc !== 16'd1) begin bad++; $display("FAIL illop_pc: got %0h want 1", pc); end
        dbg_sel = 4'd1;
        #1;
        total++; if (dbg_data !== 8'h05) begin bad++; $display("FAIL illop_r1: got %0h want 05", dbg_data); end
        step(5);
        total++; if (mem_req !== 1'b0 || state !== 3'd4) begin bad++; $display("FAIL illop_stays: got req=%0b state=%0d want 0/4", mem_req, state); end
    endtask

    task automatic test_illegal_rd;
        int c0, cycles;
        rst = 1'b1; ack_delay = 0; clear_mem;
        mem[0] <= 16'hF305;
        step(2);
        rst = 1'b0; c0 = cyc;
        run_to_halt(50, c0, cycles);
        total++; if (cycles !== 3) begin bad++; $display("FAIL illrd_cycles: got %0d want 3", cycles); end
        total++; if (illegal !== 1'b1 || halted !== 1'b1) begin bad++; $display("FAIL illrd_flags: got illegal=%0b halted=%0b want 1/1", illegal, halted); end
        total++; if (pc !== 16'd0) begin bad++; $display("FAIL illrd_pc: got %0h want 0", pc); end
        dbg_sel = 4'd7;
        #1;
        total++; if (dbg_data !== 8'h00) begin bad++; $display("FAIL illrd_r7: got %0h want 00", dbg_data); end
        step(4);
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL illrd_req: got %0b want 0", mem_req); end
    endtask

    task automatic test_async_reset;
        int n;
        rst = 1'b1; ack_delay = 4; clear_mem;
        mem[0]    <= 16'h135A;
        mem[1]    <= 16'h1620;
        mem[8'h20] <= 16'h1111;
        dbg_sel = 4'd1;
        step(2);
        rst = 1'b0;
        n = 0;
        while (state !== 3'd3 && n < 60) begin
            step(1);
            n++;
        end
        total++; if (state !== 3'd3 || mem_req !== 1'b1 || mem_we !== 1'b1) begin bad++; $display("FAIL ar_memwait: got state=%0d req=%0b we=%0b want 3/1/1", state, mem_req, mem_we); end
        total++; if (mem_addr !== 16'h0020 || mem_wdata !== 16'h005A) begin bad++; $display("FAIL ar_beat: got addr=%0h wdata=%0h want 20/005a", mem_addr, mem_wdata); end
        step(1);
        #2;
        rst = 1'b1;
        #1;
        total++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("FAIL ar_req: got req=%0b we=%0b want 0/0", mem_req, mem_we); end
        total++; if (mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin bad++; $display("FAIL ar_addr: got addr=%0h wdata=%0h want 0/0", mem_addr, mem_wdata); end
        total++; if (state !== 3'd0 || pc !== 16'h0) begin bad++; $display("FAIL ar_state: got state=%0d pc=%0h want 0/0", state, pc); end
        total++; if (out !== 8'h0 || outen !== 1'b0 || halted !== 1'b0 || illegal !== 1'b0) begin bad++; $display("FAIL ar_outs: got out=%0h outen=%0b halted=%0b illegal=%0b want 0", out, outen, halted, illegal); end
        total++; if (dbg_data !== 8'h00) begin bad++; $display("FAIL ar_regs: got %0h want 00", dbg_data); end
        ack_delay = 0;
        @(negedge clk);
        step(3);
        total++; if (mem[8'h20] !== 16'h1111) begin bad++; $display("FAIL ar_no_write: got %0h want 1111", mem[8'h20]); end
        rst = 1'b0;
        step(1);
        total++; if (state !== 3'd1 || mem_req !== 1'b1 || mem_addr !== 16'h0) begin bad++; $display("FAIL ar_refetch: got state=%0d req=%0b addr=%0h want 1/1/0", state, mem_req, mem_addr); end
    endtask

    initial begin
        test_reset;
        test_outi;
        test_addi_wrap;
        test_loop;
        test_store_load(0);
        test_store_load(3);
        test_illegal_op;
        test_illegal_rd;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/proc_multi.md
# proc_multi

Parametrised multi-cycle processor core. It is the next generation of the single-register-file test processor. Register width and register count are configurable. The memory port uses a req/ack handshake in place of address-compare polling, so it works with any memory latency. The instruction set adds load/store, add-immediate, branch and halt. It sits between the instruction/data memory model and the top-level output pins.

## Interface
Parameters:
- DATA_W, 16: register and out width. Range 8..16.
- NUM_REGS, 16: register count. Range 2..16.
- ADDR_W, 16: width of pc and mem_addr.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  write request when high, read when low
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  16  store data, zero-extended from DATA_W
- mem_rdata  in  16  read data, valid while mem_ack is high on a read
- mem_ack  in  1  request completed this cycle
- out  out  DATA_W  output value
- outen  out  1  one-cycle strobe qualifying out
- pc  out  ADDR_W  program counter
- state  out  3  current FSM state
- halted  out  1  core is stopped
- illegal  out  1  sticky flag: stopped on a bad opcode or register index
- dbg_sel  in  4  register index for the debug read port
- dbg_data  out  DATA_W  combinational regs[dbg_sel]; 0 if dbg_sel >= NUM_REGS

## Operation
- Instruction fields: [15:12] rd, [11:8] op, [7:0] imm. imm is zero-extended to DATA_W or ADDR_W as needed.
- Opcodes:
  - 0 HALT
  - 1 OUTI: out=imm
  - 2 OUTLOC: out=mem[imm][DATA_W-1:0]
  - 3 LI: rd=imm
  - 4 OUTR: out=rd
  - 5 LOAD: rd=mem[imm][DATA_W-1:0]
  - 6 STORE: mem[imm]=zext(rd)
  - 7 ADDI: rd=rd+imm, modulo 2^DATA_W
  - 8 BNZ: pc=imm if rd!=0, else pc+1
- Opcodes 9..F, or any rd >= NUM_REGS, set illegal and halted, then enter HALTED. Nothing else changes.
- FSM states: RESET, WAIT_INSTR, EXEC, MEM_WAIT, HALTED.
  - RESET → WAIT_INSTR, issuing a fetch: req=1, we=0, addr=pc.
  - WAIT_INSTR: on ack, latch the instruction and drop req → EXEC.
  - EXEC:
    - Non-memory ops complete here: pc updates and the next fetch is issued → WAIT_INSTR.
    - Memory ops issue req with addr=imm (and we/wdata for STORE) → MEM_WAIT.
    - HALT → HALTED.
  - MEM_WAIT: on ack, complete the op (LOAD writes rd, OUTLOC drives out/outen), set pc+1 and issue the fetch → WAIT_INSTR.
  - HALTED: absorbing. Only rst leaves it.
- pc increments wrap modulo 2^ADDR_W.
- outen is high for exactly one cycle per OUTI, OUTR or OUTLOC. out holds its last value otherwise.
- Register write and debug read of the same register in the same cycle: dbg_data shows the old value.

## Timing
- All outputs are registered except dbg_data.
- Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, out=0, outen=0, pc=0, state=RESET, halted=0, illegal=0. Registers are cleared to 0.
- Handshake:
  - mem_addr, mem_we and mem_wdata are stable while mem_req is high.
  - mem_ack is ignored while mem_req is low.
  - req drops on the edge after ack is sampled. A new req may be raised on that same edge.
- Zero-wait memory (ack = req): non-memory instruction takes 2 cycles, memory instruction takes 3.
- Each extra wait cycle adds exactly 1 cycle.
- rst mid-transaction drops mem_req immediately (asynchronous). No write completes after rst.

## Structure
- Package proc_pkg holds:
  - the opcode localparams (OP_HALT..OP_BNZ)
  - the e_state enum
  - the instruction field bit positions
- Sub-module proc_regfile(DATA_W, NUM_REGS):
  - one synchronous write port
  - two combinational read ports: the execute operand and the debug port
  - asynchronous clear on rst

## Test plan
- Zero-wait memory, program {0x0105 OUTI 5, 0x0000 HALT} → outen pulses once with out=5 at cycle 3. Then halted=1, illegal=0, pc=1.
- LI r1,3; ADDI r1,0xFF with DATA_W=8 → dbg_sel=1 reads 0x02 (wrap). With DATA_W=16 it reads 0x0102.
- Loop LI r2,3; ADDI r2,0xFF (DATA_W=8, decrement); BNZ r2,1; OUTR r2; HALT → BNZ taken twice, then out=0 and outen exactly once.
- STORE r1 to 0x20, then LOAD r3 from 0x20 and OUTR r3 → the write beat shows we=1, addr=0x20, wdata=value, and out equals the value. Run with ack delay 0 and ack delay 3: cycle count grows by exactly 3 per memory access.
- Opcode 0xA, or rd=15 with NUM_REGS=8 → illegal=1, halted=1, no register write, mem_req stays 0 afterwards.
- Assert rst while mem_req=1 during MEM_WAIT → all outputs return to their reset values in the same cycle. Fetch restarts at pc=0 after rst is released.
